riscv_ctrl_fsm: RTL and testbench

RISCV_CTRL_FSM -- requirements
Module: riscv_ctrl_fsm

---
 rtl/riscv_ctrl_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_fsm.sv
// rtl/riscv_ctrl_fsm.sv - multi-cycle RV32I control FSM; CTRL_PERF_CNT_EN adds cycle/instret counters
module riscv_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] inst,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        PCSel,
    output logic        PCWEn,
    output logic [2:0]  ImmSel,
    output logic        RegWEn,
    output logic        BrUn,
    output logic        BSel,
    output logic        ASel,
    output logic        MemRW,
    output logic [1:0]  WBSel,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       b_sel;
        logic       a_sel;
        logic       br_un;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef struct packed {
        logic  legal;
        logic  system;
        logic  is_load;
        logic  is_store;
        logic  is_branch;
        logic  is_jump;
        logic  rd_wr;
        ctrl_t ctrl;
    } dec_t;

    // Illegal encodings decode to all-zero so nothing leaks onto the datapath before HALT.
    function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            7'b0110011: begin d.rd_wr = 1'b1; d.ctrl.wb_sel = 2'd1; end
            7'b0010011: begin d.rd_wr = 1'b1; d.ctrl.b_sel = 1'b1; d.ctrl.wb_sel = 2'd1; end
            7'b0000011: begin
                d.is_load = 1'b1; d.rd_wr = 1'b1; d.ctrl.b_sel = 1'b1;
                d.legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            7'b0100011: begin
                d.is_store = 1'b1; d.ctrl.imm_sel = 3'd1; d.ctrl.b_sel = 1'b1;
                d.legal = !f3[2] && (f3 != 3'b011);
            end
            7'b1100011: begin
                d.is_branch = 1'b1; d.ctrl.imm_sel = 3'd2; d.ctrl.b_sel = 1'b1;
                d.ctrl.a_sel = 1'b1; d.ctrl.br_un = f3[1];
                d.legal = (f3[2:1] != 2'b01);
            end
            7'b0110111: begin d.rd_wr = 1'b1; d.ctrl.imm_sel = 3'd3; d.ctrl.b_sel = 1'b1; d.ctrl.wb_sel = 2'd1; end
            7'b0010111: begin
                d.rd_wr = 1'b1; d.ctrl.imm_sel = 3'd3; d.ctrl.b_sel = 1'b1;
                d.ctrl.a_sel = 1'b1; d.ctrl.wb_sel = 2'd1;
            end
            7'b1101111: begin
                d.is_jump = 1'b1; d.rd_wr = 1'b1; d.ctrl.imm_sel = 3'd4;
                d.ctrl.b_sel = 1'b1; d.ctrl.a_sel = 1'b1; d.ctrl.wb_sel = 2'd2;
            end
            7'b1100111: begin
                d.is_jump = 1'b1; d.rd_wr = 1'b1; d.ctrl.b_sel = 1'b1; d.ctrl.wb_sel = 2'd2;
                d.legal = (f3 == 3'b000);
            end
            7'b1110011: d.system = 1'b1;
            default:    d.legal = 1'b0;
        endcase
        if (!d.legal) d = '0;
        return d;
    endfunction

    state_t      state_q;
    logic [31:0] ir_q;
    ctrl_t       ctrl_q;
    logic        taken_q;
    logic        pc_wen_q;
    logic        reg_wen_q;
    logic        mem_rw_q;
    logic        halted_q;
    logic        illegal_q;

    dec_t dec_in;
    dec_t dec_ir;
    logic br_taken;

    assign dec_in = decode(inst[6:0], inst[14:12]);
    assign dec_ir = decode(ir_q[6:0], ir_q[14:12]);

    always_comb begin
        br_taken = 1'b0;
        case (ir_q[14:13])
            2'b00:   br_taken = ir_q[12] ? !BrEq : BrEq;
            2'b10,
            2'b11:   br_taken = ir_q[12] ? !BrLT : BrLT;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            ctrl_q    <= '0;
            taken_q   <= 1'b0;
            pc_wen_q  <= 1'b0;
            reg_wen_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_wen_q  <= 1'b0;
            reg_wen_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            taken_q   <= 1'b0;
            case (state_q)
                IDLE: if (run) state_q <= FETCH;
                FETCH: begin
                    ir_q    <= inst;
                    ctrl_q  <= dec_in.ctrl;
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (!dec_ir.legal || dec_ir.system) begin
                        state_q   <= HALT;
                        ctrl_q    <= '0;
                        halted_q  <= 1'b1;
                        illegal_q <= !dec_ir.legal;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_ir.is_load || dec_ir.is_store) begin
                        state_q  <= MEM;
                        mem_rw_q <= dec_ir.is_store;
                        pc_wen_q <= dec_ir.is_store;
                    end else begin
                        state_q   <= WB;
                        reg_wen_q <= dec_ir.rd_wr;
                        pc_wen_q  <= 1'b1;
                        taken_q   <= dec_ir.is_jump || (dec_ir.is_branch && br_taken);
                    end
                end
                MEM: begin
                    if (dec_ir.is_store) begin
                        state_q <= run ? FETCH : IDLE;
                        ctrl_q  <= '0;
                    end else begin
                        state_q   <= WB;
                        reg_wen_q <= 1'b1;
                        pc_wen_q  <= 1'b1;
                    end
                end
                WB: begin
                    state_q <= run ? FETCH : IDLE;
                    ctrl_q  <= '0;
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PCSel   = taken_q;
    assign PCWEn   = pc_wen_q;
    assign ImmSel  = ctrl_q.imm_sel;
    assign RegWEn  = reg_wen_q;
    assign BrUn    = ctrl_q.br_un;
    assign BSel    = ctrl_q.b_sel;
    assign ASel    = ctrl_q.a_sel;
    assign MemRW   = mem_rw_q;
    assign WBSel   = ctrl_q.wb_sel;
    assign halted  = halted_q;
    assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != IDLE && state_q != HALT) cycle_q <= cycle_q + 32'd1;
            if (pc_wen_q) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{inst[31:15], inst[11:7], ir_q[31:15], ir_q[11:7], dec_ir.ctrl,
                           dec_in.legal, dec_in.system, dec_in.is_load, dec_in.is_store,
                           dec_in.is_branch, dec_in.is_jump, dec_in.rd_wr};

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// tb/tb_riscv_ctrl_fsm.sv - self-checking bench for riscv_ctrl_fsm
module tb_riscv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] inst;
    logic        BrEq, BrLT;
    logic        PCSel, PCWEn, RegWEn, BrUn, BSel, ASel, MemRW, halted, illegal;
    logic [2:0]  ImmSel;
    logic [1:0]  WBSel;
    logic [31:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    riscv_ctrl_fsm dut (
        .clk(clk), .rst(rst), .run(run), .inst(inst), .BrEq(BrEq), .BrLT(BrLT),
        .PCSel(PCSel), .PCWEn(PCWEn), .ImmSel(ImmSel), .RegWEn(RegWEn), .BrUn(BrUn),
        .BSel(BSel), .ASel(ASel), .MemRW(MemRW), .WBSel(WBSel), .halted(halted),
        .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // {PCSel, PCWEn, ImmSel[2:0], RegWEn, BrUn, BSel, ASel, MemRW, WBSel[1:0], halted, illegal}
    logic [13:0] act_vec;
    assign act_vec = {PCSel, PCWEn, ImmSel, RegWEn, BrUn, BSel, ASel, MemRW, WBSel, halted, illegal};

    int          total = 0;
    int          bad = 0;
    logic        exp_valid = 1'b0;
    logic [13:0] exp_vec = '0;
    logic [13:0] fin_vec = '0;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_LUI = 5,
                   K_AUI = 6, K_JAL = 7, K_JALR = 8, K_SYS = 9, K_ILL = 10;

    logic [2:0] imm_tab [0:8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
    logic       bsel_tab[0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       asel_tab[0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] wb_tab  [0:8] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic       rd_tab  [0:8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    localparam logic [31:0] I_ADD = 32'h003100B3, I_LW = 32'h0000A083, I_SW = 32'h0010A023,
                            I_BEQ = 32'h00208463;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33:   return K_R;
            7'h13:   return K_I;
            7'h03:   return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_ILL : K_LD;
            7'h23:   return (f3 > 3'd2) ? K_ILL : K_ST;
            7'h63:   return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
            7'h37:   return K_LUI;
            7'h17:   return K_AUI;
            7'h6F:   return K_JAL;
            7'h67:   return (f3 == 3'd0) ? K_JALR : K_ILL;
            7'h73:   return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int lat(input logic [31:0] ins);
        return (kind_of(ins) == K_LD) ? 5 : 4;
    endfunction

    // Expected outputs in cycle c of an instruction (cycle 1 = FETCH).
    function automatic logic [13:0] model(input logic [31:0] ins, input int c,
                                          input logic breq, input logic brlt);
        int k;
        logic pcsel, pcwen, regwen, brun, bsel, asel, memrw, hal, ill, taken;
        logic [2:0] imm, f3;
        logic [1:0] wb;
        k = kind_of(ins);
        f3 = ins[14:12];
        {pcsel, pcwen, regwen, brun, bsel, asel, memrw, hal, ill} = '0;
        imm = '0; wb = '0;
        case (f3)
            3'd0:       taken = breq;
            3'd1:       taken = !breq;
            3'd4, 3'd6: taken = brlt;
            3'd5, 3'd7: taken = !brlt;
            default:    taken = 1'b0;
        endcase
        if (k >= K_SYS) begin
            if (c >= 3) begin hal = 1'b1; ill = (k == K_ILL); end
        end else begin
            if (c >= 2) begin
                imm = imm_tab[k]; bsel = bsel_tab[k]; asel = asel_tab[k]; wb = wb_tab[k];
                brun = (k == K_BR) && f3[1];
            end
            if (c == lat(ins)) begin
                pcwen  = 1'b1;
                pcsel  = (k == K_JAL) || (k == K_JALR) || ((k == K_BR) && taken);
                regwen = rd_tab[k];
                memrw  = (k == K_ST);
            end
        end
        return {pcsel, pcwen, imm, regwen, brun, bsel, asel, memrw, wb, hal, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) check("ctrl_vec", {18'd0, act_vec}, {18'd0, exp_vec});
    end

    task automatic do_inst(input logic [31:0] ins, input logic breq, input logic brlt, input int drop_c);
        int l;
        l = lat(ins);
        inst = ins; BrEq = breq; BrLT = brlt;
        for (int c = 1; c <= l; c++) begin
            @(posedge clk); #1;
            exp_vec = model(ins, c, breq, brlt);
            exp_valid = 1'b1;
            if (c == l) fin_vec = act_vec;
            if (c == drop_c) run = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_vec = '0;
            exp_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        run = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_vec", {18'd0, act_vec}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] prog [0:9] = '{32'h00108093, 32'h123450B7, 32'h00001097, 32'h008000EF, 32'h000080E7,
                                32'h00209463, 32'h0020E463, 32'h0020D463, I_LW, I_SW};
    logic        prog_eq[0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        prog_lt[0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] halt_ins[0:2] = '{32'hFFFFFFFF, 32'h00000073, 32'h0020A463};
    logic        halt_ill[0:2] = '{1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; run = 1'b0; inst = '0; BrEq = 1'b0; BrLT = 1'b0;
        #3;
        check("reset_vec", {18'd0, act_vec}, 32'd0);
        check("reset_cycle_cnt", cycle_cnt, 32'd0);
        check("reset_instret_cnt", instret_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);

        run = 1'b1;
        do_inst(I_ADD, 1'b0, 1'b0, 4);
        check("add_regwen", {31'd0, fin_vec[8]}, 32'd1);
        check("add_wbsel", {30'd0, fin_vec[3:2]}, 32'd1);
        check("add_pcwen", {31'd0, fin_vec[12]}, 32'd1);
        check("add_pcsel", {31'd0, fin_vec[13]}, 32'd0);
        idle_cycles(1);

        run = 1'b1;
        do_inst(I_LW, 1'b0, 1'b0, 5);
        check("lw_memrw", {31'd0, fin_vec[4]}, 32'd0);
        check("lw_regwen", {31'd0, fin_vec[8]}, 32'd1);
        check("lw_wbsel", {30'd0, fin_vec[3:2]}, 32'd0);
        idle_cycles(1);

        run = 1'b1;
        do_inst(I_SW, 1'b0, 1'b0, 4);
        check("sw_memrw", {31'd0, fin_vec[4]}, 32'd1);
        check("sw_regwen", {31'd0, fin_vec[8]}, 32'd0);
        idle_cycles(1);

        run = 1'b1;
        do_inst(I_BEQ, 1'b1, 1'b0, 0);
        check("beq_taken_pcsel", {30'd0, fin_vec[13:12]}, 32'd3);
        do_inst(I_BEQ, 1'b0, 1'b0, 4);
        check("beq_nottaken_pcsel", {30'd0, fin_vec[13:12]}, 32'd1);
        idle_cycles(1);

        run = 1'b1;
        for (int i = 0; i < 10; i++)
            do_inst(prog[i], prog_eq[i], prog_lt[i], (i == 9) ? lat(prog[i]) : 0);
        idle_cycles(1);

        run = 1'b1;
        do_inst(I_LW, 1'b0, 1'b0, 2);
        idle_cycles(2);

        do_reset();
        run = 1'b1;
        do_inst(I_ADD, 1'b0, 1'b0, 0);
        do_inst(I_ADD, 1'b0, 1'b0, 0);
        do_inst(I_ADD, 1'b0, 1'b0, 4);
        idle_cycles(2);
`ifdef CTRL_PERF_CNT_EN
        check("perf_cycle_cnt", cycle_cnt, 32'd12);
        check("perf_instret_cnt", instret_cnt, 32'd3);
`else
        check("perf_cycle_cnt_tied", cycle_cnt, 32'd0);
        check("perf_instret_cnt_tied", instret_cnt, 32'd0);
`endif

        for (int h = 0; h < 3; h++) begin
            do_reset();
            run = 1'b1;
            inst = halt_ins[h];
            for (int c = 1; c <= 7; c++) begin
                @(posedge clk); #1;
                exp_vec = model(halt_ins[h], c, 1'b0, 1'b0);
                exp_valid = 1'b1;
            end
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_illegal", {31'd0, illegal}, {31'd0, halt_ill[h]});
            check("halt_pcwen", {31'd0, PCWEn}, 32'd0);
        end

        do_reset();
        run = 1'b1;
        inst = I_SW;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_vec = model(I_SW, c, 1'b0, 1'b0);
            exp_valid = (c < 4);
        end
        check("st_mem_memrw", {31'd0, MemRW}, 32'd1);
        #1 rst = 1'b1;
        run = 1'b0;
        #1;
        check("rst_in_mem_vec", {18'd0, act_vec}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_hold_strobes", {29'd0, MemRW, PCWEn, RegWEn}, 32'd0);
        end
        rst = 1'b0;
        idle_cycles(2);
        run = 1'b1;
        do_inst(I_ADD, 1'b0, 1'b0, 4);
        idle_cycles(1);
        exp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
